pulse_meter: RTL and testbench

- Downstream consumer of the pulse generator output.
- Measures the high width and period of the `pulse` stream in clock cycles and counts complete pulse periods.
- Presents each result on a valid/ready handshake to the next stage (register bank or display logic).
- Exposes FSM state on `ST` for debug, mirroring the generator's `PS` output.

---
 rtl/pulse_meter.sv | 162 ++++++++++++++++
 tb/tb_pulse_meter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Measures high width and period of a synchronous pulse stream; results leave on valid/ready.
// Define PULSE_METER_SYNC_EN to put a 2-flop synchronizer ahead of the sampling register.
module pulse_meter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse,
  input  logic          clr,
  input  logic          ready,
  output logic          valid,
  output logic [CW-1:0] width,
  output logic [CW-1:0] period,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          lost,
  output logic [1:0]    ST
);

  typedef enum logic [1:0] {IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10} state_t;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_reg, state_next;
  logic          s_in, s_reg, s_d_reg;
  logic [CW-1:0] hcnt_reg, hcnt_next, pcnt_reg, pcnt_next;
  logic [CW-1:0] width_reg, width_next, period_reg, period_next;
  logic [CW-1:0] count_reg, count_next;
  logic          valid_reg, valid_next, ovf_reg, ovf_next, lost_reg, lost_next;
  logic          rise, fall, hsat, psat, complete;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[0], pulse};
  end

  assign s_in = sync_reg[1];
`else
  assign s_in = pulse;
`endif

  // Edge detector is deliberately left running through clr so a level held
  // across the clear is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg   <= 1'b0;
      s_d_reg <= 1'b0;
    end else begin
      s_reg   <= s_in;
      s_d_reg <= s_reg;
    end
  end

  assign rise = s_reg & ~s_d_reg;
  assign fall = ~s_reg & s_d_reg;
  assign hsat = (hcnt_reg == CMAX);
  assign psat = (pcnt_reg == CMAX);

  always_comb begin
    state_next  = state_reg;
    hcnt_next   = hcnt_reg;
    pcnt_next   = pcnt_reg;
    width_next  = width_reg;
    period_next = period_reg;
    count_next  = count_reg;
    valid_next  = valid_reg;
    ovf_next    = ovf_reg;
    lost_next   = lost_reg;
    complete    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          hcnt_next  = ONE;
          pcnt_next  = ONE;
          state_next = HIGH;
        end
      end
      HIGH: begin
        pcnt_next = psat ? CMAX : pcnt_reg + ONE;
        if (psat) ovf_next = 1'b1;
        if (s_reg) begin
          hcnt_next = hsat ? CMAX : hcnt_reg + ONE;
          if (hsat) ovf_next = 1'b1;
        end
        if (fall) state_next = LOW;
      end
      LOW: begin
        if (rise) begin
          complete   = 1'b1;
          hcnt_next  = ONE;
          pcnt_next  = ONE;
          state_next = HIGH;
        end else begin
          pcnt_next = psat ? CMAX : pcnt_reg + ONE;
          if (psat) ovf_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (valid_reg && ready) valid_next = 1'b0;

    // A completion in the accept cycle simply reloads; it only counts as lost if unread.
    if (complete) begin
      width_next  = hcnt_reg;
      period_next = pcnt_reg;
      count_next  = count_reg + ONE;
      valid_next  = 1'b1;
      if (valid_reg && !ready) lost_next = 1'b1;
    end

    if (clr) begin
      state_next  = IDLE;
      hcnt_next   = '0;
      pcnt_next   = '0;
      width_next  = '0;
      period_next = '0;
      count_next  = '0;
      valid_next  = 1'b0;
      ovf_next    = 1'b0;
      lost_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      hcnt_reg   <= '0;
      pcnt_reg   <= '0;
      width_reg  <= '0;
      period_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      lost_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hcnt_reg   <= hcnt_next;
      pcnt_reg   <= pcnt_next;
      width_reg  <= width_next;
      period_reg <= period_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      ovf_reg    <= ovf_next;
      lost_reg   <= lost_next;
    end
  end

  assign valid  = valid_reg;
  assign width  = width_reg;
  assign period = period_reg;
  assign count  = count_reg;
  assign ovf    = ovf_reg;
  assign lost   = lost_reg;
  assign ST     = state_reg;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter (CW=4 so saturation is reachable quickly).
module tb_pulse_meter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse = 1'b0;
  logic          clr = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [CW-1:0] width, period, count;
  logic          ovf, lost;
  logic [1:0]    ST;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  pulse_meter #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .clr(clr), .ready(ready),
    .valid(valid), .width(width), .period(period), .count(count),
    .ovf(ovf), .lost(lost), .ST(ST)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p);
    pulse = p;
    cyc();
  endtask

  // reps periods of 3 high / 5 low, starting from IDLE with pulse low.
  task automatic train(input int reps, input bit per_cycle);
    for (int r = 0; r < reps; r++) begin
      for (int t = 0; t < 8; t++) begin
        drive(t < 3);
        if (per_cycle) begin
          check("st_train", ST, (t == 0) ? ((r == 0) ? 0 : 2) : ((t <= 3) ? 1 : 2));
          check("valid_train", valid, (r >= 1 && t == 1));
          if (valid) begin
            exp_count++;
            check("width_train", width, 3);
            check("period_train", period, 8);
            check("count_train", count, exp_count);
            $display("result width=%0d period=%0d count=%0d", width, period, count);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held, then idle
    cyc(); cyc();
    check("rst_valid", valid, 0);
    check("rst_width", width, 0);
    check("rst_period", period, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_lost", lost, 0);
    check("rst_st", ST, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b0);
    check("idle_valid", valid, 0);
    check("idle_count", count, 0);
    check("idle_st", ST, 0);

    // Steady train, always ready
    ready = 1'b1;
    train(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      check("tail_valid", valid, 0);
    end
    check("tail_count", count, 3);
    check("tail_st", ST, 2);

    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_count", count, 0);
    check("clr_st", ST, 0);
    check("clr_valid", valid, 0);

    // Backpressure
    ready = 1'b0;
    train(2, 1'b0);
    check("bp1_valid", valid, 1);
    check("bp1_count", count, 1);
    check("bp1_lost", lost, 0);
    check("bp1_width", width, 3);
    check("bp1_period", period, 8);
    train(1, 1'b0);
    check("bp2_valid", valid, 1);
    check("bp2_count", count, 2);
    check("bp2_lost", lost, 1);
    check("bp2_width", width, 3);
    check("bp2_period", period, 8);
    ready = 1'b1; cyc(); ready = 1'b0;
    check("bp_accept_valid", valid, 0);
    check("bp_lost_sticky", lost, 1);
    check("bp_count_hold", count, 2);

    // Saturation
    clr = 1'b1; cyc(); clr = 1'b0;
    check("sat_lost_clr", lost, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1);
      if (i == 9) check("sat_ovf_early", ovf, 0);
    end
    check("sat_st_high", ST, 1);
    check("sat_ovf", ovf, 1);
    check("sat_valid_none", valid, 0);
    drive(1'b0); drive(1'b0);
    drive(1'b1); drive(1'b1);
    check("sat_valid", valid, 1);
    check("sat_width", width, 15);
    check("sat_period", period, 15);
    check("sat_count", count, 1);
    $display("result width=%0d period=%0d count=%0d ovf=%0d", width, period, count, ovf);

    // clr during HIGH
    drive(1'b1);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clrh_st", ST, 0);
    check("clrh_count", count, 0);
    check("clrh_valid", valid, 0);
    check("clrh_ovf", ovf, 0);
    drive(1'b1);
    check("clrh_no_rise", ST, 0);
    for (int i = 0; i < 4; i++) drive(1'b0);
    for (int i = 0; i < 6; i++) drive(i < 2);
    check("clrh_first_none", valid, 0);
    for (int i = 0; i < 6; i++) drive(i < 2);
    check("clrh_valid", valid, 1);
    check("clrh_width", width, 2);
    check("clrh_period", period, 6);
    check("clrh_count1", count, 1);
    check("clrh_st_low", ST, 2);

    // Async reset between edges, mid-LOW
    #3 rst = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_count", count, 0);
    check("arst_width", width, 0);
    check("arst_period", period, 0);
    check("arst_st", ST, 0);
    cyc();
    rst = 1'b1;
    drive(1'b0); drive(1'b0);
    train(2, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0);
    check("rest_valid", valid, 1);
    check("rest_width", width, 3);
    check("rest_period", period, 8);
    check("rest_count", count, 1);
    check("rest_ovf", ovf, 0);
    check("rest_lost", lost, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
